dct2d_rowcol_sched: RTL and testbench
=====================================

Name: dct2d_rowcol_sched

Overview:
- Sequencer that computes one 8x8 2-D DCT block on a single shared 1-D 8-point DCT core.
- Two passes per block:
  - Row pass: each of the 8 accepted input rows is issued to the core.
  - Column pass: the row results are transposed, and the 8 columns are issued through the same core.
- The core sits outside this block and is connected through the core_x/core_X ports. The core has a fixed pipeline depth and cannot stall.
- Results are held in an output buffer and drained through a valid/ready interface. One block is in flight at a time.

Parameters:
- W, 16, bits per sample word (core I/O word width).
- CORE_LAT, 6, cycles from core_x holding a vector to core_X holding its result.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid&&in_ready
- in_data  in  8*W  row samples; sample j in bits [W*j+W-1:W*j]
- core_x  out  8*W  registered vector to the 1-D core; word j drives core input x_j
- core_X  in  8*W  core result; word k is coefficient X_k
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid&&out_ready
- out_data  out  8*W  output beat c, word k = Y[k][c]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output beat is consumed

Behaviour:
- Reset: all outputs go to 0 (in_ready=0, out_valid=0, core_x=0, busy=0, done=0).
  - FSM goes to IDLE; all counters and the valid shift register clear.
  - Buffer contents are don't-care.
  - in_ready rises in the first cycle after rst deasserts.
- Reset mid-block: the partial block is discarded; no done pulse; there is no resume.
- Issue tracking:
  - A CORE_LAT-bit valid shift register is loaded with 1 on every issue and 0 otherwise.
  - When its tail bit is set, core_X is captured and cap_cnt (0..7) is incremented.
  - Results return in issue order, so no tag is carried.
  - core_x is loaded with 0 in any cycle with no issue.
- FSM states:
  - IDLE: in_ready=1. On accept: core_x<=in_data, row_cnt<=1, go to ROW_ISSUE.
  - ROW_ISSUE: in_ready=1.
    - Each accept loads core_x and increments row_cnt; in_valid gaps insert bubbles.
    - When row_cnt reaches 8, in_ready drops the next cycle and the FSM goes to ROW_WAIT.
  - ROW_WAIT: a capture of row result r writes tbuf[r][k]=core_X word k. After the 8th capture, go to COL_ISSUE.
  - COL_ISSUE: 8 consecutive cycles, no bubbles; cycle c loads core_x word j = tbuf[j][c]. Then go to COL_WAIT.
  - COL_WAIT: a capture of column result c writes obuf[c]=core_X. After the 8th capture, go to DRAIN.
  - DRAIN: out_valid=1, out_data=obuf[beat].
    - beat increments on each handshake.
    - While out_ready=0, out_data is held stable.
    - After the beat-7 handshake: out_valid=0, done=1 for one cycle, go to IDLE.
- Column-pass input is the row-pass result word fed bit-for-bit (Q3.12 bits presented as Q1.15). The implicit 1/8 scale is compensated downstream; no saturation or rounding is done here.
- Input is never accepted outside IDLE/ROW_ISSUE, so no back-pressure on the core is needed.
- Capturing while the valid tail bit is 0 is illegal; an assertion must flag it.
- Throughput with in_valid=1 and out_ready=1 (cycle 0 = first accept):
  - row results captured in cycles 7..14
  - COL_ISSUE in cycles 15..22
  - column results captured in cycles 22..29
  - out_valid high in cycles 30..37
  - done in cycle 38
  - in_ready high again in cycle 38

Test Plan:
- Impulse (x[0][0]=0x7FFF, others 0), continuous valid/ready:
  - out_valid first high at cycle 30, done at cycle 38.
  - Every Y matches the fixed-point golden model applied twice with bit-reinterpret between passes (±1 LSB).
- in_valid toggled 1/0 every cycle: rows are taken on 8 accepts only; core_x=0 in gap cycles; results are identical to the continuous case.
- Ramp block x[r][c]=(r*8+c)<<8, out_ready low for 5 cycles at beat 3:
  - out_data is stable during the stall.
  - Beats 0..7 arrive in order, exactly 8 handshakes, done is a single pulse.
- rst asserted in COL_WAIT:
  - All outputs are 0 immediately, with no done pulse.
  - The next block with all samples 0x1000 gives Y[0][0] ≈ 0x0100-scaled golden; all other coefficients are 0.
- Back-to-back blocks A then B with in_valid held high:
  - B's first row is accepted only in cycle 38.
  - A's outputs are not corrupted by B.
- Valid-shift-register check: the core_X capture count equals the issue count (16 per block), verified over 100 random blocks.

Source files
------------

// File: rtl/dct2d_rowcol_sched.sv
// dct2d_rowcol_sched
//   Sequences one 8x8 2-D DCT block through a single external 1-D
//   8-point DCT core: 8 row vectors go through the core first, and the
//   8 columns of the transposed row results follow. Column results are
//   buffered and drained one beat per column over a valid/ready port.
//   One block is in flight at a time.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input row handshake, in_data = 8 samples of W bits
//   core_x              registered vector presented to the 1-D core
//   core_X              core result, CORE_LAT cycles after core_x
//   out_valid/out_ready output beat handshake, out_data word k = Y[k][c]
//   busy                high whenever the sequencer is not idle
//   done                one-cycle pulse after the last beat is consumed
module dct2d_rowcol_sched #(
    parameter int W        = 16,
    parameter int CORE_LAT = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_data,
    output logic [8*W-1:0] core_x,
    input  logic [8*W-1:0] core_X,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] out_data,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE,
        ROW_ISSUE,
        ROW_WAIT,
        COL_ISSUE,
        COL_WAIT,
        DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_cnt_q, row_cnt_d;
    logic [2:0]     col_cnt_q, col_cnt_d;
    logic [2:0]     cap_cnt_q, cap_cnt_d;
    logic [2:0]     beat_q, beat_d;
    logic           done_q, done_d;
    logic           in_ready_q;
    logic [8*W-1:0] core_x_q, core_x_d;
    // x_vld_q marks that core_x currently holds an issued vector; the
    // shift register then carries that mark so its tail lines up with
    // the cycle in which core_X holds the matching result.
    logic           x_vld_q;
    logic [CORE_LAT-1:0] vsr_q;

    logic [8*W-1:0] tbuf_q [8];   // row results, indexed by row
    logic [8*W-1:0] obuf_q [8];   // column results, indexed by column

    logic           accept;
    logic           row_issue;
    logic           col_issue;
    logic           cap;
    logic           row_phase;
    logic [8*W-1:0] col_vec;

    assign accept    = in_valid && in_ready_q;
    assign cap       = vsr_q[CORE_LAT-1];
    assign row_phase = (state_q == ROW_ISSUE) || (state_q == ROW_WAIT);

    // Column c of the transposed row results: word j comes from row j.
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
        assign col_vec[gi*W +: W] = tbuf_q[gi][col_cnt_q*W +: W];
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        row_issue = 1'b0;
        col_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    row_issue = 1'b1;
                    row_cnt_d = 4'd1;
                    state_d   = ROW_ISSUE;
                end
            end
            ROW_ISSUE: begin
                if (accept) begin
                    row_issue = 1'b1;
                    row_cnt_d = row_cnt_q + 4'd1;
                    if (row_cnt_q == 4'd7) begin
                        state_d = ROW_WAIT;
                    end
                end
            end
            ROW_WAIT: begin
                if (cap && cap_cnt_q == 3'd7) begin
                    state_d = COL_ISSUE;
                end
            end
            COL_ISSUE: begin
                col_issue = 1'b1;
                col_cnt_d = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) begin
                    state_d = COL_WAIT;
                end
            end
            COL_WAIT: begin
                if (cap && cap_cnt_q == 3'd7) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Row results are fed to the column pass bit-for-bit; the
        // resulting 1/8 scale is compensated downstream.
        if (row_issue) begin
            core_x_d = in_data;
        end else if (col_issue) begin
            core_x_d = col_vec;
        end else begin
            core_x_d = '0;
        end

        cap_cnt_d = cap ? cap_cnt_q + 3'd1 : cap_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            core_x_q   <= '0;
            x_vld_q    <= 1'b0;
            vsr_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            // Registered so that it stays low while rst is asserted.
            in_ready_q <= (state_d == IDLE) || (state_d == ROW_ISSUE);
            core_x_q   <= core_x_d;
            x_vld_q    <= row_issue || col_issue;
            vsr_q      <= {vsr_q[CORE_LAT-2:0], x_vld_q};
        end
    end

    // Buffer storage carries no reset; contents are rewritten every block.
    always_ff @(posedge clk) begin
        if (cap) begin
            if (row_phase) begin
                tbuf_q[cap_cnt_q] <= core_X;
            end else begin
                obuf_q[cap_cnt_q] <= core_X;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign core_x    = core_x_q;
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? obuf_q[beat_q] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // A capture must only happen on a tracked result, and only while a
    // pass is in progress.
    a_cap_tracked : assert property (@(posedge clk) disable iff (rst)
        cap |-> vsr_q[CORE_LAT-1]);
    a_cap_state : assert property (@(posedge clk) disable iff (rst)
        cap |-> (state_q inside {ROW_ISSUE, ROW_WAIT, COL_ISSUE, COL_WAIT}));

endmodule

// File: tb/tb_dct2d_rowcol_sched.sv
module tb_dct2d_rowcol_sched;
    localparam int W = 16;
    typedef logic [8*W-1:0] vec_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    vec_t in_data   = '0;
    logic in_ready;
    vec_t core_x;
    vec_t core_X;
    logic out_valid;
    vec_t out_data;
    logic busy;
    logic done;

    // Orthonormal DCT-II coefficients scaled by 32768.
    int A [8][8] = '{
        '{ 11585,  11585,  11585,  11585,  11585,  11585,  11585,  11585},
        '{ 16070,  13623,   9102,   3196,  -3196,  -9102, -13623, -16070},
        '{ 15137,   6270,  -6270, -15137, -15137,  -6270,   6270,  15137},
        '{ 13623,  -3196, -16070,  -9102,   9102,  16070,   3196, -13623},
        '{ 11585, -11585, -11585,  11585,  11585, -11585, -11585,  11585},
        '{  9102, -16070,   3196,  13623, -13623,  -3196,  16070,  -9102},
        '{  6270, -15137,  15137,  -6270,  -6270,  15137, -15137,   6270},
        '{  3196,  -9102,  13623, -16070,  16070, -13623,   9102,  -3196}
    };

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    vec_t exp_q [$];
    vec_t blk [8];
    vec_t got_blk [8];
    vec_t core_pipe [6];
    int   hs_blk = 0, done_cnt = 0, blk_start = 0, gap_rel = 0;
    int   first_ov_rel = 0, done_rel = 0;
    bit   ov_seen = 1'b0, stall_prev = 1'b0;
    vec_t stall_data = '0;

    dct2d_rowcol_sched #(.W(W), .CORE_LAT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_x    (core_x),
        .core_X    (core_X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input Q1.15, output Q3.12: X_k = sum x_n*A[k][n] / 2^18.
    function automatic vec_t dct1d(input vec_t v);
        vec_t   r;
        longint acc;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                acc += longint'($signed(v[n*W +: W])) * longint'(A[k][n]);
            end
            acc = acc >>> 18;
            r[k*W +: W] = acc[W-1:0];
        end
        return r;
    endfunction

    // Core model: fixed 6-cycle latency, never stalls.
    always @(posedge clk) begin
        core_pipe[0] <= dct1d(core_x);
        for (int i = 1; i < 6; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_X = core_pipe[5];

    task automatic check(input string name, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_expected();
        vec_t rr [8];
        vec_t cv;
        for (int r = 0; r < 8; r++) rr[r] = dct1d(blk[r]);
        for (int c = 0; c < 8; c++) begin
            cv = '0;
            for (int j = 0; j < 8; j++) cv[j*W +: W] = rr[j][c*W +: W];
            exp_q.push_back(dct1d(cv));
        end
    endtask

    function automatic vec_t rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_row(input vec_t d);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        acc      = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL row_accept: got no accept, required one within 200 cycles");
        end
    endtask

    task automatic send_block(input bit gaps, input bit hold);
        for (int r = 0; r < 8; r++) begin
            send_row(blk[r]);
            if (gaps) begin
                check($sformatf("gap_issue_r%0d", r), core_x, blk[r]);
                in_valid = 1'b0;
                in_data  = rand_vec();
                @(posedge clk);
                #1;
                check($sformatf("gap_zero_r%0d", r), core_x, '0);
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: got no done pulse, required one within %0d cycles", budget);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_rel = cyc - blk_start;
                end
                if (stall_prev && out_valid) check("stall_hold", out_data, stall_data);
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h, required no beat", out_data);
                    end else begin
                        check($sformatf("beat%0d", hs_blk), out_data, exp_q.pop_front());
                    end
                    if (hs_blk < 8) got_blk[hs_blk] = out_data;
                    hs_blk++;
                end
                if (in_valid && in_ready && !busy) begin
                    gap_rel   = cyc - blk_start;
                    blk_start = cyc;
                    hs_blk    = 0;
                    ov_seen   = 1'b0;
                end
                if (out_valid && !ov_seen) begin
                    ov_seen      = 1'b1;
                    first_ov_rel = cyc - blk_start;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", vec_t'(in_ready), '0);
        check("rst_out_valid", vec_t'(out_valid), '0);
        check("rst_core_x", core_x, '0);
        check("rst_busy", vec_t'(busy), '0);
        check("rst_done", vec_t'(done), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", vec_t'(in_ready), 1);
        out_ready = 1'b1;

        // Impulse, continuous.
        for (int r = 0; r < 8; r++) blk[r] = '0;
        blk[0][W-1:0] = 16'h7FFF;
        push_expected();
        send_block(1'b0, 1'b0);
        wait_done(100);
        check("imp_first_valid", first_ov_rel, 30);
        check("imp_done_cycle", done_rel, 38);
        check("imp_y00", vec_t'(got_blk[0][W-1:0]), 63);
        check("imp_y10", vec_t'(got_blk[0][2*W-1:W]), 88);

        // Impulse with in_valid toggling.
        push_expected();
        send_block(1'b1, 1'b0);
        wait_done(100);
        check("gap_y00", vec_t'(got_blk[0][W-1:0]), 63);

        // Ramp, output stall at beat 3.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk[r][c*W +: W] = 16'((r*8 + c) << 8);
        d0 = done_cnt;
        push_expected();
        send_block(1'b0, 1'b0);
        for (int t = 0; t < 100 && hs_blk < 3; t++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        check("ramp_handshakes", hs_blk, 8);
        check("ramp_single_done", done_cnt, d0 + 1);

        // Reset during COL_WAIT.
        for (int r = 0; r < 8; r++) blk[r] = rand_vec();
        send_block(1'b0, 1'b0);
        for (int t = 0; t < 100 && (cyc - blk_start) < 25; t++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", vec_t'(in_ready), '0);
        check("mid_rst_out_valid", vec_t'(out_valid), '0);
        check("mid_rst_core_x", core_x, '0);
        check("mid_rst_busy", vec_t'(busy), '0);
        check("mid_rst_done", vec_t'(done), '0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_rst_in_ready_back", vec_t'(in_ready), 1);
        check("mid_rst_no_done", done_cnt, d0);

        // Flat block 0x1000.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk[r][c*W +: W] = 16'h1000;
        push_expected();
        send_block(1'b0, 1'b0);
        wait_done(100);
        check("flat_y00", vec_t'(got_blk[0][W-1:0]), 511);
        check("flat_y_k0_rest", vec_t'(got_blk[0][8*W-1:W]), '0);
        check("flat_beat1", got_blk[1], '0);

        // Back-to-back A then B with in_valid held high.
        for (int r = 0; r < 8; r++) blk[r] = rand_vec();
        push_expected();
        send_block(1'b0, 1'b1);
        for (int r = 0; r < 8; r++) blk[r] = rand_vec();
        push_expected();
        send_block(1'b0, 1'b0);
        wait_done(100);
        check("b2b_second_accept", gap_rel, 38);
        check("b2b_done_cycle", done_rel, 38);

        // Random blocks.
        for (int b = 0; b < 100; b++) begin
            for (int r = 0; r < 8; r++) blk[r] = rand_vec();
            push_expected();
            send_block(b % 3 == 0, 1'b0);
            wait_done(200);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
